fetch_seq: RTL

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq_pkg.sv | 31 +++
 rtl/fetch_seq.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding,
// special opcodes and the instruction field positions.
// Latency: n/a (types and constants only). Backpressure: n/a.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_HALTED    = 3'd4
    } state_e;

    localparam logic [2:0] OPC_HALT = 3'b110;
    localparam logic [2:0] OPC_JMP  = 3'b111;

    // Instruction word layout: [7:5] opcode, [4:0] operand
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int OPD_MSB = 4;
    localparam int OPD_LSB = 0;

    function automatic logic [2:0] get_opcode(input logic [7:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [4:0] get_operand(input logic [7:0] instr);
        return instr[OPD_MSB:OPD_LSB];
    endfunction

endpackage

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: walks an external ROM by PC and issues words to a consumer.
// Latency: one FETCH cycle registers rom_data, instruction presented in the following ISSUE cycle.
// Backpressure: instr_out/instr_valid held stable in ISSUE until instr_ready; PC advances only on handshake.
//
// Ports: clk/reset (async active-high); start, step_mode, step control execution;
// rom_addr/rom_data form the combinational ROM lookup; instr_out/instr_valid/instr_ready
// is the valid-ready issue interface; busy (FETCH or ISSUE) and halted report status.
// Optional feature: define FETCH_SEQ_JUMP_EN to decode opcode 3'b111 as a jump to operand.
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int          PC_W     = 4,
    parameter int unsigned START_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            step_mode,
    input  logic            step,
    output logic [PC_W-1:0] rom_addr,
    input  logic [7:0]      rom_data,
    output logic [7:0]      instr_out,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            busy,
    output logic            halted
);

    localparam logic [PC_W-1:0] PC_INIT = PC_W'(START_PC);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [7:0]      r_ir;
    logic [7:0]      w_ir_nxt;
    logic [2:0]      w_opcode;
    logic            w_hs;

    assign w_opcode  = get_opcode(r_ir);
    assign rom_addr  = r_pc;
    assign instr_out = r_ir;
    // Handshake only counts while a non-HALT word is actually being offered.
    assign w_hs      = instr_valid & instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= PC_INIT;
            r_ir    <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        instr_valid = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_pc_nxt    = PC_INIT;
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                busy        = 1'b1;
                w_ir_nxt    = rom_data;
                w_state_nxt = ST_ISSUE;
            end

            ST_ISSUE: begin
                busy = 1'b1;
                if (w_opcode == OPC_HALT) begin
                    // HALT is consumed internally, never shown to the consumer.
                    w_state_nxt = ST_HALTED;
                end else begin
                    instr_valid = 1'b1;
                    if (instr_ready) begin
`ifdef FETCH_SEQ_JUMP_EN
                        if (w_opcode == OPC_JMP) begin
                            w_pc_nxt = PC_W'(get_operand(r_ir));
                        end else begin
                            w_pc_nxt = r_pc + PC_W'(1);
                        end
`else
                        w_pc_nxt = r_pc + PC_W'(1);
`endif
                        w_state_nxt = step_mode ? ST_STEP_WAIT : ST_FETCH;
                    end
                end
            end

            ST_STEP_WAIT: begin
                // Leaving single-step mode releases the sequencer as if stepped.
                if (step || !step_mode) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_HALTED: begin
                halted = 1'b1;
                if (start) begin
                    w_pc_nxt    = PC_INIT;
                    w_state_nxt = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // w_hs is kept as a named term for readability of the handshake rule;
    // the transition logic above uses the same condition in expanded form.
    logic w_hs_unused;
    assign w_hs_unused = w_hs;

endmodule
